// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/capture stage for the 12-bit combinational ALU; optional repeat via ALU_ISSUE_REPEAT_EN
module alu_issue_ctrl #(
  parameter int WIDTH = 12,
  parameter int SEL_W = 6,
  parameter int REP_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [SEL_W-1:0] CmdOp,
  input  logic             CmdCarry,
  input  logic             CmdUseAcc,
  input  logic [WIDTH-1:0] CmdA,
  input  logic [WIDTH-1:0] CmdB,
`ifdef ALU_ISSUE_REPEAT_EN
  input  logic [REP_W-1:0] CmdRepeat,
`endif
  output logic [SEL_W-1:0] Sel,
  output logic             CarryIn,
  output logic [WIDTH-1:0] A_1,
  output logic [WIDTH-1:0] B_1,
  input  logic [WIDTH-1:0] AluY,
  output logic             ResValid,
  input  logic             ResReady,
  output logic [WIDTH-1:0] ResData,
  output logic             ResZero,
  output logic             ResNeg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_res_valid;
  logic [REP_W-1:0] r_rep_cnt;

  logic             w_accept;
  logic             w_is_nop;
  logic [WIDTH-1:0] w_a_src;
  logic [REP_W-1:0] w_rep_in;

  // Handshake and operand selection for the command being accepted
  assign CmdReady = (r_state == S_IDLE) && !Reset;
  assign w_accept = CmdValid && CmdReady;
  assign w_is_nop = CmdOp[SEL_W-1];
  assign w_a_src  = CmdUseAcc ? r_acc : CmdA;

`ifdef ALU_ISSUE_REPEAT_EN
  assign w_rep_in = w_is_nop ? '0 : CmdRepeat;
`else
  assign w_rep_in = '0;
`endif

  // Issue FSM: latch ALU inputs on accept, capture AluY in EXEC, hold result in DONE
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_res_valid <= 1'b0;
      r_rep_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sel     <= CmdOp;
            r_carry   <= CmdCarry;
            r_a       <= w_a_src;
            r_b       <= CmdB;
            r_rep_cnt <= w_rep_in;
            if (w_is_nop) begin
              // ALU holds its output for this select, so nothing is captured
              r_state     <= S_DONE;
              r_res_valid <= 1'b1;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_acc <= AluY;
          if (r_rep_cnt != '0) begin
            // Chain the result back into operand A for the next iteration
            r_a       <= AluY;
            r_rep_cnt <= r_rep_cnt - 1'b1;
          end else begin
            r_state     <= S_DONE;
            r_res_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (ResReady) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  // Registered drives and result flags taken from the accumulator
  assign Sel      = r_sel;
  assign CarryIn  = r_carry;
  assign A_1      = r_a;
  assign B_1      = r_b;
  assign ResValid = r_res_valid;
  assign ResData  = r_acc;
  assign ResZero  = (r_acc == '0);
  assign ResNeg   = r_acc[WIDTH-1];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

  logic        Clk;
  logic        Reset;
  logic        CmdValid;
  logic        CmdReady;
  logic [5:0]  CmdOp;
  logic        CmdCarry;
  logic        CmdUseAcc;
  logic [11:0] CmdA;
  logic [11:0] CmdB;
  logic [3:0]  CmdRepeat;
  logic [5:0]  Sel;
  logic        CarryIn;
  logic [11:0] A_1;
  logic [11:0] B_1;
  logic [11:0] AluY;
  logic        ResValid;
  logic        ResReady;
  logic [11:0] ResData;
  logic        ResZero;
  logic        ResNeg;

  alu_issue_ctrl #(.WIDTH(12), .SEL_W(6), .REP_W(4)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .CmdValid  (CmdValid),
    .CmdReady  (CmdReady),
    .CmdOp     (CmdOp),
    .CmdCarry  (CmdCarry),
    .CmdUseAcc (CmdUseAcc),
    .CmdA      (CmdA),
    .CmdB      (CmdB),
`ifdef ALU_ISSUE_REPEAT_EN
    .CmdRepeat (CmdRepeat),
`endif
    .Sel       (Sel),
    .CarryIn   (CarryIn),
    .A_1       (A_1),
    .B_1       (B_1),
    .AluY      (AluY),
    .ResValid  (ResValid),
    .ResReady  (ResReady),
    .ResData   (ResData),
    .ResZero   (ResZero),
    .ResNeg    (ResNeg)
  );

  // Behavioural ALU: 0 inc-by-carry, 1 add, 2 subtract, 3 and, 4 or, 5 xor
  function automatic logic [11:0] alu_f(input logic [5:0] s, input logic c,
                                        input logic [11:0] a, input logic [11:0] b);
    logic [11:0] cc;
    cc = {11'd0, c};
    case (s[4:0])
      5'd0:    return a + cc;
      5'd1:    return a + b + cc;
      5'd2:    return a + ~b + cc;
      5'd3:    return a & b;
      5'd4:    return a | b;
      5'd5:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign AluY = alu_f(Sel, CarryIn, A_1, B_1);

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int edge_cnt = 0;
  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [11:0] data;
    int          acc_edge;
    int          delta;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] mdl_acc = 12'd0;
  logic        prev_valid = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result monitor: pop the scoreboard when ResValid rises and compare
  always @(negedge Clk) begin
    if (!Reset && ResValid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_result", 32'(ResValid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("res_latency", 32'(edge_cnt - e.acc_edge), 32'(e.delta));
        check_val("res_data", 32'(ResData), 32'(e.data));
        check_val("res_zero", 32'(ResZero), 32'(e.data == 12'd0));
        check_val("res_neg", 32'(ResNeg), 32'(e.data[11]));
      end
    end
    prev_valid = ResValid;
  end

  task automatic send(input logic [5:0] op, input logic c, input logic u,
                      input logic [11:0] a, input logic [11:0] b, input int rep);
    int          n;
    exp_t        e;
    logic [11:0] x;
    logic [11:0] a_eff;
    n = 0;
    @(negedge Clk);
    while (!CmdReady && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!CmdReady) check_val("cmd_ready_timeout", 32'(CmdReady), 32'd1);
    CmdValid  = 1'b1;
    CmdOp     = op;
    CmdCarry  = c;
    CmdUseAcc = u;
    CmdA      = a;
    CmdB      = b;
    CmdRepeat = 4'(rep);
    a_eff = u ? mdl_acc : a;
    if (op[5]) begin
      e.data  = mdl_acc;
      e.delta = 0;
    end else begin
      x = a_eff;
      for (int i = 0; i <= rep; i++) x = alu_f(op, c, x, b);
      mdl_acc = x;
      e.data  = x;
      e.delta = rep + 1;
    end
    e.acc_edge = edge_cnt + 1;
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    CmdValid = 1'b0;
    check_val("issue_sel", 32'(Sel), 32'(op));
    check_val("issue_carry", 32'(CarryIn), 32'(c));
    check_val("issue_a", 32'(A_1), 32'(a_eff));
    check_val("issue_b", 32'(B_1), 32'(b));
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge Clk);
    while ((sb_q.size() != 0 || !CmdReady) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check_val("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1; CmdValid = 1'b0; CmdOp = '0; CmdCarry = 1'b0; CmdUseAcc = 1'b0;
    CmdA = '0; CmdB = '0; CmdRepeat = '0; ResReady = 1'b1;
    repeat (3) @(negedge Clk);
    check_val("reset_cmd_ready", 32'(CmdReady), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check_val("rst_sel", 32'(Sel), 32'd0);
    check_val("rst_carry", 32'(CarryIn), 32'd0);
    check_val("rst_a", 32'(A_1), 32'd0);
    check_val("rst_b", 32'(B_1), 32'd0);
    check_val("rst_res_data", 32'(ResData), 32'd0);
    check_val("rst_res_valid", 32'(ResValid), 32'd0);
    check_val("idle_cmd_ready", 32'(CmdReady), 32'd1);

    // First command after reset uses the cleared accumulator
    send(6'b000001, 1'b0, 1'b1, 12'h7FF, 12'd3, 0);
    send(6'b000001, 1'b0, 1'b0, 12'd5, 12'd3, 0);
    send(6'b000010, 1'b1, 1'b0, 12'd7, 12'd7, 0);
    send(6'b000000, 1'b1, 1'b1, 12'd0, 12'd0, 0);
    send(6'b000010, 1'b1, 1'b0, 12'd0, 12'd1, 0);
    drain();

    // Backpressure: result and flags held, no new command accepted
    ResReady = 1'b0;
    send(6'b000001, 1'b0, 1'b0, 12'h010, 12'h020, 0);
    n = 0;
    while (!ResValid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check_val("bp_valid", 32'(ResValid), 32'd1);
      check_val("bp_data", 32'(ResData), 32'h030);
      check_val("bp_cmd_ready", 32'(CmdReady), 32'd0);
    end
    ResReady = 1'b1;
    @(negedge Clk);
    check_val("bp_release_ready", 32'(CmdReady), 32'd1);
    check_val("bp_release_valid", 32'(ResValid), 32'd0);

    // NOP keeps the accumulator and skips EXEC
    send(6'b000001, 1'b0, 1'b0, 12'h0A0, 12'h005, 0);
    send(6'b100000, 1'b0, 1'b0, 12'h123, 12'h456, 0);
    drain();

    // Reset during EXEC drops the command
    @(negedge Clk);
    CmdValid = 1'b1; CmdOp = 6'b000001; CmdCarry = 1'b0; CmdUseAcc = 1'b0;
    CmdA = 12'd3; CmdB = 12'd4; CmdRepeat = '0;
    @(posedge Clk);
    #1;
    CmdValid = 1'b0;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check_val("midrst_sel", 32'(Sel), 32'd0);
    check_val("midrst_carry", 32'(CarryIn), 32'd0);
    check_val("midrst_a", 32'(A_1), 32'd0);
    check_val("midrst_b", 32'(B_1), 32'd0);
    check_val("midrst_data", 32'(ResData), 32'd0);
    check_val("midrst_valid", 32'(ResValid), 32'd0);
    check_val("midrst_ready", 32'(CmdReady), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    mdl_acc = 12'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check_val("midrst_no_valid", 32'(ResValid), 32'd0);
    end
    send(6'b000001, 1'b0, 1'b1, 12'hFFF, 12'd4, 0);

`ifdef ALU_ISSUE_REPEAT_EN
    send(6'b000000, 1'b1, 1'b0, 12'd1, 12'd0, 3);
    send(6'b000001, 1'b0, 1'b0, 12'd2, 12'd3, 15);
    send(6'b100000, 1'b0, 1'b0, 12'd9, 12'd9, 7);
`endif

    // Random commands, including accumulator chaining
    for (int i = 0; i < 10; i++) begin
      int rep;
      rep = 0;
`ifdef ALU_ISSUE_REPEAT_EN
      rep = $urandom_range(0, 3);
`endif
      send(6'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           12'($urandom), 12'($urandom), rep);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
